// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter byte port among NUM_CH byte sources.
// Arbitration is round-robin with packet locking. A granted channel keeps the
// transmitter until it marks its last byte, hits MAX_BYTES, or leaves
// req_valid low for TIMEOUT cycles. An optional header byte
// (HDR_BASE + channel) opens every granted burst so the far end can
// demultiplex the serial stream.

// Per-channel qualifier. It gates one source onto the shared byte bus and
// returns that source's ready strobe while this channel owns the DATA phase.
module uart_tx_arb_lane (
    input  logic       sel_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    input  logic       tx_ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       last_o,
    output logic       ready_o
);
    // AND-gate everything so the top can simply OR the lanes together.
    always_comb begin
        data_o  = sel_i ? data_i : 8'h00;
        valid_o = sel_i & valid_i;
        last_o  = sel_i & last_i;
        ready_o = sel_i & tx_ready_i;
    end
endmodule

module uart_tx_arbiter #(
    parameter int         NUM_CH    = 4,
    parameter int         HDR_EN    = 1,
    parameter logic [7:0] HDR_BASE  = 8'hA0,
    parameter int         MAX_BYTES = 16,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH*8-1:0] req_data_i,
    input  logic [NUM_CH-1:0]   req_valid_i,
    input  logic [NUM_CH-1:0]   req_last_i,
    output logic [NUM_CH-1:0]   req_ready_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [NUM_CH-1:0]   grant_o,
    output logic                busy_o
);
    localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BCW = $clog2(MAX_BYTES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Terminal counts: the transfer/stall that lands on these releases the grant.
    localparam logic [BCW-1:0] BYTE_LAST  = BCW'(MAX_BYTES - 1);
    localparam logic [15:0]    STALL_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [NUM_CH-1:0]      lane_sel;
    logic [NUM_CH-1:0]      lane_vld;
    logic [NUM_CH-1:0]      lane_last;
    logic [NUM_CH-1:0]      lane_rdy;
    logic [NUM_CH-1:0][7:0] lane_data;

    logic [7:0]    sel_data;
    logic          sel_vld;
    logic          sel_last;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          xfer;
    logic          rel;
    logic [7:0]    hdr_byte;

    // Only the owner's lane is opened, and only once the header (if any) is out.
    assign lane_sel = (state_q == S_DATA) ? grant_q : '0;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
            uart_tx_arb_lane u_lane (
                .sel_i      (lane_sel[g]),
                .data_i     (req_data_i[8*g +: 8]),
                .valid_i    (req_valid_i[g]),
                .last_i     (req_last_i[g]),
                .tx_ready_i (tx_ready_i),
                .data_o     (lane_data[g]),
                .valid_o    (lane_vld[g]),
                .last_o     (lane_last[g]),
                .ready_o    (lane_rdy[g])
            );
        end
    endgenerate

    // Collapse the one-hot gated lanes into the owner's byte/valid/last.
    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | lane_data[i];
        end
        sel_vld  = |lane_vld;
        sel_last = |lane_last;
    end

    // Rotating-priority search: first requester after the last winner, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = int'(rr_q) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!pick_vld && req_valid_i[c]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(c);
            end
        end
    end

    // Header tag wraps mod 256 by construction of the 8-bit add.
    assign hdr_byte = HDR_BASE + 8'(idx_q);

    // Transmitter-side outputs are purely combinational from state and inputs.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        case (state_q)
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hdr_byte;
            end
            S_DATA: begin
                tx_valid_o = sel_vld;
                tx_data_o  = sel_data;
            end
            default: ;
        endcase
    end

    assign xfer        = tx_valid_o & tx_ready_i;
    assign req_ready_o = lane_rdy;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);

    // Grant lifecycle: arbitrate, optional header, locked data until release.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        rel         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d           = (HDR_EN != 0) ? S_HDR : S_DATA;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    idx_d             = pick_idx;
                    rr_d              = pick_idx;
                    byte_cnt_d        = '0;
                    stall_cnt_d       = '0;
                end
            end
            S_HDR: begin
                if (xfer) state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer && (sel_last || byte_cnt_q == BYTE_LAST)) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    byte_cnt_d  = byte_cnt_q + BCW'(1);
                    stall_cnt_d = '0;
                end else if (sel_vld) begin
                    // Valid but transmitter busy is not a stall.
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == STALL_LAST) begin
                    rel = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
                if (rel) begin
                    state_d     = S_IDLE;
                    grant_d     = '0;
                    byte_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves channel 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            rr_q        <= IW'(NUM_CH - 1);
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed scenarios plus randomized traffic. A cycle-level reference model
// (owner index, header flag, byte/stall tallies) predicts every output each
// cycle; per-channel packet queues act as sources and a simple busy-timer
// stands in for the UART transmitter.
module tb_uart_tx_arbiter;
    localparam int         NCH  = 4;
    localparam int         MAXB = 4;
    localparam int         TOUT = 16;
    localparam logic [7:0] HB   = 8'hA0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*8-1:0]  req_data;
    logic [NCH-1:0]    req_valid, req_last, req_ready, grant;
    logic [7:0]        tx_data;
    logic              tx_valid, tx_ready, busy;

    uart_tx_arbiter #(
        .NUM_CH(NCH), .HDR_EN(1), .HDR_BASE(HB), .MAX_BYTES(MAXB), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // sources: queue entries are {last, data}
    logic [8:0] src_q [NCH][$];
    int pause_after [NCH];
    int block [NCH];
    int push_cnt [NCH];
    int dut_acc [NCH];
    int rdy_pulses [NCH];
    int en_pct = 100;
    int tx_max = 0;
    int tx_busy = 0;
    int st_obs0 = 0;
    logic [7:0] stream [$];
    logic [7:0] ex [$];

    // reference model
    int m_own = -1;
    bit m_hdr = 1'b0;
    int m_nb = 0;
    int m_st = 0;
    int m_rr = NCH - 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        src_q[ch].push_back({l, d});
        push_cnt[ch]++;
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < NCH; i++) begin
            h = (src_q[i].size() > 0) ? src_q[i][0] : 9'h000;
            req_data[i*8 +: 8] = h[7:0];
            req_last[i]        = h[8];
            req_valid[i]       = (src_q[i].size() > 0) && (block[i] == 0) &&
                                 ($urandom_range(0, 99) < en_pct);
        end
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < NCH; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check at negedge, advance model, then update sources/tx at posedge+1.
    task automatic tick();
        logic [NCH-1:0] e_rdy, e_grant, acc;
        logic [7:0]     e_td;
        logic           e_tv, e_busy, hs, found;
        logic [8:0]     h;
        int w;
        @(negedge clk);
        e_rdy = '0; e_grant = '0; e_tv = 1'b0; e_td = 8'h00; e_busy = 1'b0;
        if (!rst_n) begin
            m_own = -1; m_hdr = 1'b0; m_nb = 0; m_st = 0; m_rr = NCH - 1;
        end else if (m_own >= 0) begin
            e_busy = 1'b1;
            e_grant[m_own] = 1'b1;
            if (m_hdr) begin
                e_tv = 1'b1;
                e_td = HB + 8'(m_own);
            end else begin
                e_tv = req_valid[m_own];
                e_td = req_data[m_own*8 +: 8];
                e_rdy[m_own] = tx_ready;
            end
        end
        chk("tx_valid",  32'(tx_valid),  32'(e_tv));
        chk("tx_data",   32'(tx_data),   32'(e_td));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("grant",     32'(grant),     32'(e_grant));
        chk("busy",      32'(busy),      32'(e_busy));

        if (rst_n && tx_valid && tx_ready) stream.push_back(tx_data);
        for (int i = 0; i < NCH; i++) begin
            if (rst_n && req_ready[i]) rdy_pulses[i]++;
            if (rst_n && req_ready[i] && req_valid[i]) dut_acc[i]++;
        end
        if (rst_n && grant[0] && !req_valid[0]) st_obs0++;

        hs  = e_tv && tx_ready;
        acc = e_rdy & req_valid;
        if (rst_n) begin
            if (m_own < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    w = (m_rr + k) % NCH;
                    if (!found && req_valid[w]) begin
                        found = 1'b1;
                        m_own = w; m_rr = w; m_hdr = 1'b1; m_nb = 0; m_st = 0;
                    end
                end
            end else if (m_hdr) begin
                if (tx_ready) m_hdr = 1'b0;
            end else if (hs && (req_last[m_own] || m_nb == MAXB - 1)) begin
                m_own = -1; m_nb = 0; m_st = 0;
            end else begin
                if (hs) m_nb++;
                if (req_valid[m_own]) m_st = 0;
                else if (m_st == TOUT - 1) begin
                    m_own = -1; m_nb = 0; m_st = 0;
                end else m_st++;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (acc[i]) begin
                h = src_q[i].pop_front();
                if (pause_after[i] > 0) begin
                    block[i] = pause_after[i];
                    pause_after[i] = 0;
                end
            end else if (block[i] > 0) block[i]--;
        end
        if (hs) tx_busy = $urandom_range(0, tx_max);
        else if (tx_busy > 0) tx_busy--;
        tx_ready = (tx_busy == 0);
        drive_inputs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((src_pending() || m_own >= 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic cmp_stream(input string tag, input logic [7:0] exq [$]);
        chk({tag, "_len"}, 32'(stream.size()), 32'(exq.size()));
        for (int i = 0; i < exq.size() && i < stream.size(); i++)
            chk(tag, 32'(stream[i]), 32'(exq[i]));
        stream.delete();
    endtask

    initial begin
        int n;
        int len;
        for (int i = 0; i < NCH; i++) begin
            pause_after[i] = 0; block[i] = 0; push_cnt[i] = 0;
            dut_acc[i] = 0; rdy_pulses[i] = 0;
        end
        tx_ready = 1'b1;
        drive_inputs();

        // reset state
        repeat (3) tick();
        chk("rst_tx_valid",  32'(tx_valid),  32'd0);
        chk("rst_tx_data",   32'(tx_data),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req_busy", 32'(busy), 32'd0);

        // single packet on ch2
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b1);
        drive_inputs();
        tick();
        chk("t1_grant", 32'(grant), 32'h4);
        drain("t1_drain", 50);
        ex = '{8'hA2, 8'h11, 8'h22};
        cmp_stream("t1_stream", ex);

        // simultaneous start right after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            rdy_pulses[i] = 0;
            push(i, 8'(8'h10 + 8'h11 * i), 1'b1);
        end
        drive_inputs();
        drain("t2_drain", 50);
        ex = '{8'hA0, 8'h10, 8'hA1, 8'h21, 8'hA2, 8'h32, 8'hA3, 8'h43};
        cmp_stream("t2_stream", ex);
        for (int i = 0; i < NCH; i++) chk("t2_rdy_pulses", 32'(rdy_pulses[i]), 32'd1);

        // round-robin fairness between ch1 and ch3
        ex.delete();
        for (int k = 0; k < 4; k++) begin
            push(1, 8'(8'h10 + k), 1'b1);
            push(3, 8'(8'h30 + k), 1'b1);
            ex.push_back(8'hA1); ex.push_back(8'(8'h10 + k));
            ex.push_back(8'hA3); ex.push_back(8'(8'h30 + k));
        end
        drive_inputs();
        drain("t3_drain", 100);
        cmp_stream("t3_stream", ex);

        // byte limit forces release mid-packet
        for (int k = 0; k < 6; k++) push(0, 8'(k), k == 5);
        push(1, 8'h77, 1'b1);
        drive_inputs();
        drain("t4_drain", 100);
        ex = '{8'hA0, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA1, 8'h77, 8'hA0, 8'h04, 8'h05};
        cmp_stream("t4_stream", ex);

        // stall timeout
        st_obs0 = 0;
        push(0, 8'h55, 1'b0);
        push(0, 8'h66, 1'b1);
        pause_after[0] = 20;
        drive_inputs();
        tick();
        push(1, 8'h99, 1'b1);
        drive_inputs();
        drain("t5_drain", 150);
        chk("t5_stall_cycles", 32'(st_obs0), 32'd16);
        ex = '{8'hA0, 8'h55, 8'hA1, 8'h99, 8'hA0, 8'h66};
        cmp_stream("t5_stream", ex);

        // reset in the middle of a ch3 packet
        push(3, 8'hC1, 1'b0);
        push(3, 8'hC2, 1'b0);
        push(3, 8'hC3, 1'b1);
        drive_inputs();
        n = 0;
        while (!(m_own == 3 && !m_hdr) && n < 20) begin
            tick();
            n++;
        end
        chk("t6_reach_data", 32'(n < 20), 32'd1);
        stream.delete();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_valid",  32'(tx_valid),  32'd0);
        chk("t6_rst_grant",     32'(grant),     32'd0);
        chk("t6_rst_busy",      32'(busy),      32'd0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        push(0, 8'hD0, 1'b1);
        drive_inputs();
        #1;
        chk("t6_post_tx_valid",  32'(tx_valid),  32'd0);
        chk("t6_post_grant",     32'(grant),     32'd0);
        chk("t6_post_busy",      32'(busy),      32'd0);
        chk("t6_post_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t6_grant_ch0", 32'(grant), 32'h1);
        drain("t6_drain", 100);
        ex = '{8'hA0, 8'hD0, 8'hA3, 8'hC1, 8'hC2, 8'hC3};
        cmp_stream("t6_stream", ex);

        // randomized traffic with valid gaps, tx backpressure, stalls and a reset
        en_pct = 70;
        tx_max = 4;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (src_q[i].size() < 8 && $urandom_range(0, 99) < 4) begin
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                    if ($urandom_range(0, 7) == 0) pause_after[i] = $urandom_range(8, 24);
                end
            end
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            drive_inputs();
            tick();
        end
        en_pct = 100;
        drive_inputs();
        drain("rnd_drain", 5000);
        stream.delete();
        for (int i = 0; i < NCH; i++) chk("bytes_accepted", 32'(dut_acc[i]), 32'(push_cnt[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
